// File: rtl/pub_reg_reader_pkg.sv
// Shared types and constants for the register-bank reader.
// Optional build macro: PUB_REG_READER_PARITY_EN (see pub_reg_reader.sv).
package pub_reg_reader_pkg;

  // Scan sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SNAP = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int DEF_NREGS = 4;
  localparam int DEF_WIDTH = 8;

  // Width of an index into a bank of n registers (at least one bit).
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pub_reg_shadow.sv
// Snapshot bank: captures the whole flat register bank in one cycle when
// load is high and presents one word selected by rd_idx.
module pub_reg_shadow
  import pub_reg_reader_pkg::*;
#(
  parameter int NREGS = DEF_NREGS,
  parameter int WIDTH = DEF_WIDTH,
  parameter int IDXW  = idx_w(NREGS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load,
  input  logic [NREGS*WIDTH-1:0] regs_i,
  input  logic [IDXW-1:0]        rd_idx,
  output logic [WIDTH-1:0]       rd_data
);

  // Shadow words; kept as a plainly named array so the harness can reach them.
  logic [WIDTH-1:0] shadow_reg [NREGS];

  // Capture every word of the live bank on the same edge for a coherent view.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NREGS; k++) shadow_reg[k] <= '0;
    end else if (load) begin
      for (int k = 0; k < NREGS; k++) shadow_reg[k] <= regs_i[k*WIDTH +: WIDTH];
    end
  end

  assign rd_data = shadow_reg[rd_idx];

endmodule

// File: rtl/pub_reg_reader.sv
// Register-bank reader: on start, snapshots NREGS registers and streams them
// over a valid/ready port with index, last flag and running XOR checksum.
// Optional build macro: PUB_REG_READER_PARITY_EN adds out_parity and a sticky
// parity_err flag that catches shadow words altered behind the scan's back.
module pub_reg_reader
  import pub_reg_reader_pkg::*;
#(
  parameter int NREGS = DEF_NREGS,
  parameter int WIDTH = DEF_WIDTH,
  localparam int IDXW = idx_w(NREGS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [NREGS*WIDTH-1:0] regs_i,
  output logic                   busy,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic [IDXW-1:0]        out_idx,
  output logic                   out_last,
  output logic                   done,
  output logic [WIDTH-1:0]       checksum
`ifdef PUB_REG_READER_PARITY_EN
  ,
  output logic                   out_parity,
  output logic                   parity_err
`endif
);

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NREGS - 1);

  state_t           state_reg, state_next;
  logic [IDXW-1:0]  idx_reg;
  logic [WIDTH-1:0] checksum_reg;
  logic [WIDTH-1:0] shadow_data;
  logic             load;
  logic             handshake;
  logic             is_last;
  logic             accept_start;

  assign load         = (state_reg == SNAP);
  assign accept_start = (state_reg == IDLE) && start;
  assign is_last      = (idx_reg == LAST_IDX);
  // out_valid is purely state-decoded, so ready never feeds back into valid.
  assign handshake    = (state_reg == SEND) && out_ready;

  pub_reg_shadow #(
    .NREGS (NREGS),
    .WIDTH (WIDTH),
    .IDXW  (IDXW)
  ) u_shadow (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .regs_i  (regs_i),
    .rd_idx  (idx_reg),
    .rd_data (shadow_data)
  );

  // Next-state logic for the snapshot/stream sequence.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = SNAP;
      SNAP:    state_next = SEND;
      SEND:    if (handshake && is_last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State, word index and checksum registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      idx_reg      <= '0;
      checksum_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (accept_start) checksum_reg <= '0;
      else if (handshake) checksum_reg <= checksum_reg ^ shadow_data;
      if (load) idx_reg <= '0;
      else if (handshake && !is_last) idx_reg <= idx_reg + 1'b1;
    end
  end

  assign busy      = (state_reg != IDLE);
  assign out_valid = (state_reg == SEND);
  assign out_last  = out_valid && is_last;
  assign done      = (state_reg == DONE);
  assign out_data  = shadow_data;
  assign out_idx   = idx_reg;
  assign checksum  = checksum_reg;

`ifdef PUB_REG_READER_PARITY_EN
  // Parity of each word as captured, compared against the shadow word at its
  // handshake; a difference means the shadow was rewritten mid-scan.
  logic [NREGS-1:0] live_par;
  logic [NREGS-1:0] snap_par_reg;
  logic             parity_err_reg;

  for (genvar gi = 0; gi < NREGS; gi++) begin : g_par
    assign live_par[gi] = ^regs_i[gi*WIDTH +: WIDTH];
  end

  // Record snapshot parity alongside the shadow load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) snap_par_reg <= '0;
    else if (load) snap_par_reg <= live_par;
  end

  // Sticky error, cleared when a new scan is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) parity_err_reg <= 1'b0;
    else if (accept_start) parity_err_reg <= 1'b0;
    else if (handshake && ((^shadow_data) != snap_par_reg[idx_reg])) parity_err_reg <= 1'b1;
  end

  assign out_parity = ^shadow_data;
  assign parity_err = parity_err_reg;
`endif

endmodule

// File: tb/tb_pub_reg_reader.sv
// Self-checking bench for pub_reg_reader (NREGS=4, WIDTH=8).
module tb_pub_reg_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] regs_i;
  logic        busy, out_valid, out_ready, out_last, done;
  logic [7:0]  out_data, checksum;
  logic [1:0]  out_idx;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pub_reg_reader #(.NREGS(4), .WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .regs_i    (regs_i),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .done      (done),
    .checksum  (checksum)
  );

  typedef struct {
    logic [31:0] bank;  // word k in bits [8k+7:8k]
    logic [7:0]  cs;    // expected XOR of the four words
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model of one scan: words come out in index order from the
  // bank as it stood at start time, one per accepted handshake.
  // mode 0: ready always high; 1: random ready; 2: ready low 3 cycles at idx 1.
  task automatic do_scan(input logic [31:0] bank, input int mode, input logic [7:0] exp_cs,
                         input bit change_w2, input bit start_mid, input string tag);
    int cnt = 0;
    int stall = 0;
    int budget = 0;
    int dones = 0;
    bit hs;
    regs_i    = bank;
    start     = 1'b1;
    out_ready = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, " snap busy"}, busy, 1);
    chk({tag, " snap valid"}, out_valid, 0);
    chk({tag, " snap cs clr"}, checksum, 0);
    tick();
    if (change_w2) regs_i[23:16] = 8'hFF;
    while (cnt < 4) begin
      if (budget > 200) begin
        chk({tag, " timeout"}, cnt, 4);
        break;
      end
      budget++;
      case (mode)
        1: out_ready = ($urandom_range(0, 3) != 0);
        2: if (cnt == 1 && stall < 3) begin out_ready = 1'b0; stall++; end
           else out_ready = 1'b1;
        default: out_ready = 1'b1;
      endcase
      start = (start_mid && cnt == 1 && budget == 2);
      chk({tag, " valid"}, out_valid, 1);
      chk({tag, " data"}, out_data, bank[cnt*8 +: 8]);
      chk({tag, " idx"}, out_idx, cnt);
      chk({tag, " last"}, out_last, (cnt == 3));
      chk({tag, " no done"}, done, 0);
      hs = out_ready;
      $display("%s: word idx=%0d data=0x%02h ready=%0d", tag, out_idx, out_data, out_ready);
      tick();
      start = 1'b0;
      if (hs) cnt++;
    end
    out_ready = $urandom_range(0, 1);
    chk({tag, " done"}, done, 1);
    chk({tag, " done valid"}, out_valid, 0);
    chk({tag, " done busy"}, busy, 1);
    chk({tag, " checksum"}, checksum, exp_cs);
    tick();
    chk({tag, " idle done"}, done, 0);
    chk({tag, " idle busy"}, busy, 0);
    chk({tag, " cs hold"}, checksum, exp_cs);
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done) dones++;
      chk({tag, " stays idle"}, busy, 0);
    end
    chk({tag, " extra done"}, dones, 0);
    $display("%s: scan complete checksum=0x%02h", tag, checksum);
  endtask

  initial begin
    logic [31:0] rb;
    logic [7:0]  rcs;

    tbl[0] = '{32'h44332211, 8'h44};
    tbl[1] = '{32'h00000000, 8'h00};
    tbl[2] = '{32'h000000FF, 8'hFF};
    tbl[3] = '{32'h08040201, 8'h0F};
    tbl[4] = '{32'h00FF5AA5, 8'h00};
    tbl[5] = '{32'h01018080, 8'h00};
    tbl[6] = '{32'h78563412, 8'h08};

    rst_n = 1'b0; start = 1'b0; out_ready = 1'b0; regs_i = 32'h0;
    repeat (3) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("rst busy", busy, 0);
      chk("rst valid", out_valid, 0);
      chk("rst last", out_last, 0);
      chk("rst done", done, 0);
      chk("rst data", out_data, 0);
      chk("rst idx", out_idx, 0);
      chk("rst cs", checksum, 0);
    end
    $display("reset/idle: done");

    for (int v = 0; v < 7; v++) do_scan(tbl[v].bank, 0, tbl[v].cs, 1'b0, 1'b0, $sformatf("table%0d", v));

    do_scan(32'h44332211, 2, 8'h44, 1'b0, 1'b0, "backpressure");
    do_scan(32'h44332211, 0, 8'h44, 1'b1, 1'b0, "coherence");
    do_scan(32'h44332211, 0, 8'h44, 1'b0, 1'b1, "start_busy");

    for (int r = 0; r < 20; r++) begin
      rb = $urandom;
      rcs = 8'h00;
      for (int k = 0; k < 4; k++) rcs = rcs ^ rb[k*8 +: 8];
      do_scan(rb, 1, rcs, 1'b0, 1'b0, $sformatf("random%0d", r));
    end

    // Reset in the middle of a scan after two handshakes.
    regs_i = 32'h44332211; out_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    chk("mid cs pre", checksum, 8'h33);
    chk("mid idx pre", out_idx, 2);
    rst_n = 1'b0;
    #1;
    chk("mid rst valid", out_valid, 0);
    chk("mid rst cs", checksum, 0);
    chk("mid rst busy", busy, 0);
    chk("mid rst idx", out_idx, 0);
    chk("mid rst data", out_data, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mid rst no done", done, 0);
    end
    rst_n = 1'b1;
    tick();
    chk("after rst no done", done, 0);
    $display("reset mid-scan: outputs cleared");
    do_scan(32'h44332211, 0, 8'h44, 1'b0, 1'b0, "after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pub_reg_reader.md
Name: pub_reg_reader

Overview:
- Reader side for clocked public-flat-rw register banks: the harness or upstream logic writes the bank; this block reads it back out.
- On request, takes a coherent snapshot of NREGS registers, then streams them one per handshake over a valid/ready port with index, last flag and running XOR checksum.
- Sits in the regression top beside the register writers; lets the test verify values written via public access without tearing.

Parameters:
- NREGS, 4, number of registers in the bank (2..16).
- WIDTH, 8, bits per register.

Ports:
- clk  input  1  single clock; all state on posedge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  scan request; sampled in IDLE only.
- regs_i  input  NREGS*WIDTH  flat register bank; reg k = regs_i[k*WIDTH +: WIDTH].
- busy  output  1  high from the cycle after start is accepted until DONE is left.
- out_valid  output  1  data word available.
- out_ready  input  1  consumer accepts word.
- out_data  output  WIDTH  snapshot word.
- out_idx  output  $clog2(NREGS)  index of out_data.
- out_last  output  1  high with the word at idx NREGS-1.
- done  output  1  one-cycle pulse after the last handshake.
- checksum  output  WIDTH  XOR of all words handshaken in the current or most recent scan.

Behaviour:
- Reset (async assert, sync release): state=IDLE; busy, out_valid, out_last, done = 0; out_data, out_idx, checksum, shadow = 0.
- FSM states: IDLE, SNAP, SEND, DONE.
- IDLE: start=1 -> SNAP; checksum cleared to 0 on the same edge.
- SNAP: one cycle; shadow <= regs_i; idx <= 0 -> SEND. Later changes to regs_i do not affect the scan in flight.
- SEND: out_valid=1; out_data=shadow[idx]; out_last=(idx==NREGS-1).
  - out_data, out_idx and out_last stay stable while out_valid=1 and out_ready=0.
  - Handshake (out_valid & out_ready) does checksum ^= out_data.
  - If not last: idx++ and stay in SEND.
  - If last: -> DONE.
  - First word is valid 2 cycles after start is sampled; with out_ready tied high, one word per cycle.
- DONE: done=1, out_valid=0 for one cycle -> IDLE. checksum holds until the next start.
- start is ignored outside IDLE; no queuing.
- Index never wraps within a scan. out_idx is reset to 0 at SNAP.
- out_valid never depends combinationally on out_ready. out_ready may be high when out_valid is low; it has no effect.
- If rst_n asserts mid-scan, the scan is abandoned immediately, all outputs return to reset values, and no done pulse is issued.
- The shadow bank and checksum carry public_flat_rw @(clk) so the harness can inspect them.

Optional Feature:
- PUB_REG_READER_PARITY_EN defined:
  - Adds output out_parity (1 bit) = ^out_data, valid with out_valid.
  - Adds output parity_err (1 bit), sticky. It sets if a shadow word changes between SNAP and its handshake, which can only happen through public write access. It clears on start or reset.
- Not defined: both ports absent; no extra logic.

Decomposition:
- Package pub_reg_reader_pkg holds:
  - state_t enum {IDLE, SNAP, SEND, DONE} (2-bit encoding);
  - localparam function idx width helper;
  - default NREGS/WIDTH constants.
- One sub-module, pub_reg_shadow: NREGS x WIDTH snapshot bank with load enable, async reset and indexed read mux. FSM, checksum and handshake stay in the top.

Test Plan:
- Reset then idle: rst_n=0 for 3 cycles, then 1 with start=0 -> all outputs 0, busy=0 for 10 cycles.
- Basic scan, out_ready=1: regs={0x11,0x22,0x33,0x44} (idx0..3), start pulse -> words 0x11,0x22,0x33,0x44 on 4 consecutive cycles starting 2 cycles after start; out_last only on 0x44; done pulse next cycle; checksum=0x44.
- Backpressure: out_ready low for 3 cycles while idx=1 is presented -> out_data=0x22 and out_idx=1 held stable; sequence and checksum otherwise unchanged.
- Snapshot coherence: change regs_i word 2 to 0xFF the cycle after SNAP -> streamed word 2 is still 0x33.
- Start while busy: second start pulse mid-SEND -> ignored; exactly one done pulse and 4 handshakes.
- Reset mid-scan: assert rst_n after 2 handshakes -> out_valid=0 and checksum=0 immediately; no done pulse. A new start afterwards gives a full scan from idx 0.
